fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_if.sv | 12 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_controller.sv | 62 ++++++
 tb/tb_fetch_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DROP = 2'd3} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus
interface fetch_if
  import fetch_pkg::*;
#(parameter int ADDR_W = 32);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [INSTR_W-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry in-order buffer of fetched {pc, instruction} pairs
module fetch_fifo
  import fetch_pkg::*;
#(parameter int ADDR_W = 32) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [1:0]         count,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);
  logic [ADDR_W-1:0] pc_mem [FETCH_DEPTH];
  logic [INSTR_W-1:0] instr_mem [FETCH_DEPTH];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count < 2'(FETCH_DEPTH) || do_pop);
  assign head_pc = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
  // storage, pointers and count; flush empties the buffer in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        pc_mem[i] <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr] <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: fetch FSM and PC feeding a two-entry instruction buffer
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_if.master            imem,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DROP = ST_DROP;
  logic [1:0] state, state_nxt, count;
  logic [ADDR_W-1:0] pc;
  logic pop, push, room;
  assign pop = if_valid && id_ready;
  assign push = state == S_WAIT && imem.rvalid && !redirect_valid;
  assign room = count == 2'd0 || (count == 2'd1 && pop);
  assign if_valid = count != 2'd0;
  assign imem.req = state == S_REQ;
  assign imem.addr = pc;
  // next state; a redirect with a request still in flight waits out its response in DROP
  always_comb
    if (redirect_valid)
      state_nxt = ((state == S_WAIT || state == S_DROP) && !imem.rvalid) || (state == S_REQ && imem.gnt) ? S_DROP : S_REQ;
    else
      state_nxt = state == S_IDLE ? (count < 2'(FETCH_DEPTH) ? S_REQ : S_IDLE)
                : state == S_REQ ? (imem.gnt ? S_WAIT : S_REQ)
                : imem.rvalid ? (state == S_DROP || room ? S_REQ : S_IDLE)
                : state;
  // state and PC; a grant advances the PC, a redirect replaces it with the word-aligned target
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc & ~ADDR_W'(PC_INC - 1);
      else if (state == S_REQ && imem.gnt) pc <= pc + ADDR_W'(PC_INC);
    end
  fetch_fifo #(.ADDR_W(ADDR_W)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .push_pc(pc - ADDR_W'(PC_INC)),
    .push_instr(imem.rdata),
    .count(count),
    .head_pc(if_pc),
    .head_instr(if_instr)
  );
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized and directed checks against a queue-based fetch model
module tb_fetch_controller;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic id_ready = 1'b0;
  logic if_valid;
  logic [31:0] if_instr, if_pc;
  fetch_if #(.ADDR_W(32)) imem();
  fetch_controller #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );
  always #5 clk = ~clk;
  ent_t m_q[$];
  logic [31:0] m_pc = '0, m_ppc = '0, mem_addr = '0;
  logic m_req = 1'b0, m_pend = 1'b0, m_junk = 1'b0, mem_pend = 1'b0;
  int mem_lat = 0, lat_max = 0, rv_pct = 100, total = 0, bad = 0;
  logic [31:0] addr_log[$], pc_log[$], instr_log[$];

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // outputs the model says must be visible this cycle
  task automatic compare();
    chk("imem_req", imem.req, m_req);
    if (m_req) chk("imem_addr", imem.addr, m_pc);
    chk("if_valid", if_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("if_pc", if_pc, m_q[0].pc);
      chk("if_instr", if_instr, m_q[0].instr);
    end
  endtask

  // apply inputs for the next edge and advance memory and model accordingly
  task automatic drive(input logic g, input logic rv_en, input logic rdy, input logic rd, input logic [31:0] rpc, input logic force_rv);
    logic rv, pop;
    int n;
    rv = force_rv || (rv_en && mem_pend && mem_lat == 0 && int'($urandom_range(99)) < rv_pct);
    imem.gnt = g;
    imem.rvalid = rv;
    imem.rdata = (rv && mem_pend) ? instr_of(mem_addr) : $urandom;
    id_ready = rdy;
    redirect_valid = rd;
    redirect_pc = rpc;
    if (imem.req && g) addr_log.push_back(imem.addr);
    if (if_valid && rdy) begin
      pc_log.push_back(if_pc);
      instr_log.push_back(if_instr);
    end
    if (rv) mem_pend = 1'b0;
    else if (mem_pend && mem_lat > 0) mem_lat--;
    if (m_req && g) begin
      mem_pend = 1'b1;
      mem_addr = m_pc;
      mem_lat = int'($urandom_range(lat_max, 0));
    end
    pop = m_q.size() != 0 && rdy;
    if (rd) begin
      m_q.delete();
      if (m_pend && rv) m_pend = 1'b0;
      else if (m_req && g) m_pend = 1'b1;
      m_junk = m_pend;
      m_req = !m_pend;
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_req && g) begin
      m_pend = 1'b1;
      m_junk = 1'b0;
      m_ppc = m_pc;
      m_pc = m_pc + 32'd4;
      m_req = 1'b0;
      if (pop) void'(m_q.pop_front());
    end else if (m_pend && rv) begin
      n = m_q.size() - int'(pop);
      if (pop) void'(m_q.pop_front());
      if (!m_junk) m_q.push_back(ent_t'{m_ppc, instr_of(m_ppc)});
      m_req = m_junk || n == 0;
      m_pend = 1'b0;
      m_junk = 1'b0;
    end else begin
      if (!m_req && !m_pend) m_req = m_q.size() < 2;
      if (pop) void'(m_q.pop_front());
    end
  endtask

  task automatic step(input logic g, input logic rv_en, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    compare();
    drive(g, rv_en, rdy, rd, rpc, 1'b0);
  endtask

  task automatic do_reset(input logic stale_rv);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_imem_req", imem.req, 32'd0);
    chk("rst_imem_addr", imem.addr, 32'd0);
    chk("rst_if_valid", if_valid, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete();
    m_pc = '0;
    m_ppc = '0;
    m_req = 1'b0;
    m_pend = 1'b0;
    m_junk = 1'b0;
    mem_pend = 1'b0;
    addr_log.delete();
    pc_log.delete();
    instr_log.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, stale_rv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    // streaming fetch, stale response after reset ignored
    do_reset(1'b1);
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("seq_grants", addr_log.size() >= 3, 32'd1);
    chk("seq_addr0", addr_log[0], 32'h0);
    chk("seq_addr1", addr_log[1], 32'h4);
    chk("seq_addr2", addr_log[2], 32'h8);
    chk("seq_rate", pc_log.size(), 32'd5);
    chk("seq_pc0", pc_log[0], 32'h0);
    chk("seq_pc1", pc_log[1], 32'h4);
    chk("seq_pc2", pc_log[2], 32'h8);
    chk("seq_instr0", instr_log[0], 32'hC0DE_0000);
    chk("seq_instr2", instr_log[2], 32'hC0DE_0008);
    // decode stall fills the buffer and stops requests
    do_reset(1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req", imem.req, 32'd0);
    chk("stall_grants", addr_log.size(), 32'd2);
    chk("stall_head_pc", if_pc, 32'h0);
    chk("stall_head_instr", if_instr, 32'hC0DE_0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_addr", addr_log.size() >= 3 ? addr_log[2] : 32'hFFFF_FFFF, 32'h8);
    chk("resume_head", if_pc, 32'h4);
    // grant withheld: request held stable
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("hold_req", imem.req, 32'd1);
      chk("hold_addr", imem.addr, 32'h0);
    end
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_grant", addr_log.size() >= 1 ? addr_log[0] : 32'hFFFF_FFFF, 32'h0);
    // redirect while waiting on PC 8
    do_reset(1'b0);
    n = 0;
    while (!(m_pend && m_ppc == 32'h8) && n < 20) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("reach_wait8", m_pend && m_ppc == 32'h8, 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("drop_valid", if_valid, 32'd0);
    chk("drop_req", imem.req, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_req", imem.req, 32'd1);
    chk("redir_addr", imem.addr, 32'h100);
    chk("redir_valid", if_valid, 32'd0);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_pc1", pc_log.size() >= 3 ? pc_log[1] : 32'hFFFF_FFFF, 32'h4);
    chk("redir_pc2", pc_log.size() >= 3 ? pc_log[2] : 32'hFFFF_FFFF, 32'h100);
    // redirect coinciding with response
    do_reset(1'b0);
    n = 0;
    while (!m_pend && n < 20) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("reach_wait", m_pend, 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("coinc_req", imem.req, 32'd1);
    chk("coinc_addr", imem.addr, 32'h200);
    chk("coinc_valid", if_valid, 32'd0);
    // reset in the middle of a wait with one entry buffered
    do_reset(1'b0);
    n = 0;
    while (!(m_pend && m_q.size() == 1) && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("reach_wait_one", m_pend && m_q.size() == 1, 32'd1);
    @(negedge clk);
    chk("pre_rst_valid", if_valid, 32'd1);
    chk("pre_rst_req", imem.req, 32'd0);
    do_reset(1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_addr", addr_log.size() >= 1 ? addr_log[0] : 32'hFFFF_FFFF, 32'h0);
    chk("restart_pc", pc_log.size() >= 1 ? pc_log[0] : 32'hFFFF_FFFF, 32'h0);
    chk("restart_instr", instr_log.size() >= 1 ? instr_log[0] : 32'hFFFF_FFFF, 32'hC0DE_0000);
    // randomized traffic
    lat_max = 2;
    rv_pct = 70;
    do_reset(1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(1'($urandom_range(1, 0)));
      step(1'($urandom_range(99) < 60), 1'b1, 1'($urandom_range(99) < 70), 1'($urandom_range(19) == 0), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
